// File: rtl/fuel_pkg.sv
// Shared types and default constants for the fuel/timer countdown controller.
package fuel_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StHold  = 3'd4
  } fuel_state_t;

  localparam int unsigned DefWidth      = 8;
  localparam int unsigned DefLoadValue  = 100;
  localparam int unsigned DefDecStep    = 1;
  localparam int unsigned DefRefill     = 20;
  localparam int unsigned DefLowThresh  = 15;
  localparam int unsigned DefHoldTicks  = 1;
  localparam bit          DefAutoReload = 1'b0;

endpackage

// File: rtl/fuel_sat_update.sv
// Combinational count update: subtract step, add refill, clamp to 0..CEIL.
module fuel_sat_update #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CEIL   = 100,
  parameter int unsigned STEP   = 1,
  parameter int unsigned REFILL = 20
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             tick_i,
  input  logic             refill_i,
  output logic [WIDTH-1:0] next_o,
  output logic             zero_o
);

  localparam int unsigned EW = WIDTH + 2;

  // Two guard bits keep both the underflow sign and the refill overshoot visible.
  logic signed [EW-1:0] sum;

  always_comb begin
    sum = signed'({2'b00, count_i});
    if (tick_i) sum = sum - signed'(EW'(STEP));
    if (refill_i) sum = sum + signed'(EW'(REFILL));
    if (sum < 0) begin
      next_o = '0;
    end else if (sum > signed'(EW'(CEIL))) begin
      next_o = WIDTH'(CEIL);
    end else begin
      next_o = sum[WIDTH-1:0];
    end
  end

  assign zero_o = (next_o == '0);

endmodule

// File: rtl/fuel_countdown_ctrl.sv
// Fuel/timer gauge: arm/run/pause/hold FSM with a saturating down-counter.
module fuel_countdown_ctrl
  import fuel_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned LOAD_VALUE  = DefLoadValue,
  parameter int unsigned DEC_STEP    = DefDecStep,
  parameter int unsigned REFILL      = DefRefill,
  parameter int unsigned LOW_THRESH  = DefLowThresh,
  parameter int unsigned HOLD_TICKS  = DefHoldTicks,
  parameter bit          AUTO_RELOAD = DefAutoReload
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startN,
  input  logic             waitN,
  input  logic             OneSecPulse,
  input  logic             refillPulse,
  output logic [WIDTH-1:0] count,
  output logic             timerEnd,
  output logic             running,
  output logic             lowFuel
);

  localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  fuel_state_t      state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             timer_end_q, timer_end_d;

  logic             upd_tick, upd_refill, upd_zero;
  logic [WIDTH-1:0] upd_next;

  // Ticks only consume fuel in RUN; refills count in any active state.
  assign upd_tick   = (state_q == StRun) && OneSecPulse;
  assign upd_refill = refillPulse &&
                      ((state_q == StRun) || (state_q == StPause) || (state_q == StHold));

  fuel_sat_update #(
    .WIDTH  (WIDTH),
    .CEIL   (LOAD_VALUE),
    .STEP   (DEC_STEP),
    .REFILL (REFILL)
  ) u_sat_update (
    .count_i  (count_q),
    .tick_i   (upd_tick),
    .refill_i (upd_refill),
    .next_o   (upd_next),
    .zero_o   (upd_zero)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hold_d      = hold_q;
    timer_end_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!startN) state_d = StArm;
      end
      StArm: begin
        count_d = WIDTH'(LOAD_VALUE);
        if (startN) state_d = StRun;
      end
      StRun: begin
        count_d = upd_next;
        if (upd_tick && upd_zero) begin
          timer_end_d = 1'b1;
          if (AUTO_RELOAD) begin
            count_d = WIDTH'(LOAD_VALUE);
          end else begin
            count_d = '0;
            state_d = StIdle;
          end
        end else if (!waitN) begin
          state_d = StPause;
        end
      end
      StPause: begin
        count_d = upd_next;
        if (waitN) begin
          if (HOLD_TICKS == 0) begin
            state_d = StRun;
          end else begin
            state_d = StHold;
            hold_d  = HW'(HOLD_TICKS);
          end
        end
      end
      StHold: begin
        count_d = upd_next;
        if (!waitN) begin
          state_d = StPause;
        end else if (OneSecPulse) begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HW'(1)) state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StIdle;
      count_q     <= '0;
      hold_q      <= '0;
      timer_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      timer_end_q <= timer_end_d;
    end
  end

  assign count    = count_q;
  assign timerEnd = timer_end_q;
  assign running  = (state_q == StRun);
  assign lowFuel  = (count_q != '0) && (count_q <= WIDTH'(LOW_THRESH));

endmodule

// File: tb/tb_fuel_countdown_ctrl.sv
// Directed bench: one-shot instance and an auto-reload instance sharing tick/refill/wait.
module tb_fuel_countdown_ctrl;

  logic       clk = 1'b0;
  logic       resetN, resetN_a;
  logic       startN, startN_a;
  logic       waitN;
  logic       OneSecPulse, refillPulse;
  logic [7:0] count, count_a;
  logic       timerEnd, timerEnd_a, running, running_a, lowFuel, lowFuel_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fuel_countdown_ctrl #(
    .WIDTH(8), .LOAD_VALUE(20), .DEC_STEP(1), .REFILL(5), .LOW_THRESH(5),
    .HOLD_TICKS(2), .AUTO_RELOAD(1'b0)
  ) u_dut (
    .clk(clk), .resetN(resetN), .startN(startN), .waitN(waitN),
    .OneSecPulse(OneSecPulse), .refillPulse(refillPulse),
    .count(count), .timerEnd(timerEnd), .running(running), .lowFuel(lowFuel)
  );

  fuel_countdown_ctrl #(
    .WIDTH(8), .LOAD_VALUE(20), .DEC_STEP(1), .REFILL(5), .LOW_THRESH(5),
    .HOLD_TICKS(2), .AUTO_RELOAD(1'b1)
  ) u_dut_auto (
    .clk(clk), .resetN(resetN_a), .startN(startN_a), .waitN(waitN),
    .OneSecPulse(OneSecPulse), .refillPulse(refillPulse),
    .count(count_a), .timerEnd(timerEnd_a), .running(running_a), .lowFuel(lowFuel_a)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; outputs are settled 1 time unit after the edge.
  task automatic cyc(input logic t, input logic r);
    OneSecPulse = t;
    refillPulse = r;
    @(posedge clk);
    #1;
    OneSecPulse = 1'b0;
    refillPulse = 1'b0;
  endtask

  initial begin
    resetN = 1'b1; resetN_a = 1'b1;
    startN = 1'b1; startN_a = 1'b1;
    waitN = 1'b1; OneSecPulse = 1'b0; refillPulse = 1'b0;
    #1;
    resetN = 1'b0; resetN_a = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_running", 32'(running), 0);
    check("rst_timerend", 32'(timerEnd), 0);
    check("rst_lowfuel", 32'(lowFuel), 0);
    @(posedge clk); #1;
    resetN = 1'b1; resetN_a = 1'b1;

    // Arm for three cycles, then run down to expiry.
    startN = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    startN = 1'b1;
    cyc(1'b0, 1'b0);
    check("start_count", 32'(count), 20);
    check("start_running", 32'(running), 1);
    repeat (19) cyc(1'b1, 1'b0);
    check("pre_exp_count", 32'(count), 1);
    check("pre_exp_low", 32'(lowFuel), 1);
    check("pre_exp_te", 32'(timerEnd), 0);
    cyc(1'b1, 1'b0);
    check("exp_te", 32'(timerEnd), 1);
    check("exp_count", 32'(count), 0);
    check("exp_running", 32'(running), 0);
    check("exp_low", 32'(lowFuel), 0);
    cyc(1'b0, 1'b0);
    check("exp_te_single", 32'(timerEnd), 0);

    // Restart, run to 12, pause across 5 ticks, then the 2-tick resume hold.
    startN = 1'b0;
    cyc(1'b0, 1'b0);
    startN = 1'b1;
    cyc(1'b0, 1'b0);
    repeat (8) cyc(1'b1, 1'b0);
    check("run_to_12", 32'(count), 12);
    waitN = 1'b0;
    cyc(1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0);
    check("pause_count", 32'(count), 12);
    check("pause_running", 32'(running), 0);
    waitN = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("hold_t1_count", 32'(count), 12);
    check("hold_t1_running", 32'(running), 0);
    cyc(1'b1, 1'b0);
    check("hold_t2_count", 32'(count), 12);
    check("hold_t2_running", 32'(running), 1);
    cyc(1'b1, 1'b0);
    check("resume_dec", 32'(count), 11);

    // Interrupted hold must restart from the full two ticks.
    waitN = 1'b0;
    cyc(1'b0, 1'b0);
    waitN = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    waitN = 1'b0;
    cyc(1'b0, 1'b0);
    check("rehold_pause_running", 32'(running), 0);
    waitN = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("rehold_t1_running", 32'(running), 0);
    check("rehold_t1_count", 32'(count), 11);
    cyc(1'b1, 1'b0);
    check("rehold_t2_running", 32'(running), 1);
    cyc(1'b1, 1'b0);
    check("rehold_dec", 32'(count), 10);

    // Refill and saturation, then a tick+refill netting at low fuel.
    cyc(1'b0, 1'b1);
    check("refill_15", 32'(count), 15);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("at_18", 32'(count), 18);
    cyc(1'b0, 1'b1);
    check("refill_sat", 32'(count), 20);
    repeat (17) cyc(1'b1, 1'b0);
    check("at_3", 32'(count), 3);
    check("at_3_low", 32'(lowFuel), 1);
    cyc(1'b1, 1'b1);
    check("net_count", 32'(count), 7);
    check("net_low", 32'(lowFuel), 0);

    // Expiry beats a simultaneous pause request.
    repeat (6) cyc(1'b1, 1'b0);
    check("at_1", 32'(count), 1);
    waitN = 1'b0;
    cyc(1'b1, 1'b0);
    check("exp_wait_te", 32'(timerEnd), 1);
    check("exp_wait_count", 32'(count), 0);
    check("exp_wait_running", 32'(running), 0);
    waitN = 1'b1;
    cyc(1'b0, 1'b0);
    check("exp_wait_idle", 32'(running), 0);

    // Auto-reload instance: expiry reloads and keeps running; async reset clears.
    startN_a = 1'b0;
    cyc(1'b0, 1'b0);
    startN_a = 1'b1;
    cyc(1'b0, 1'b0);
    check("ar_start", 32'(count_a), 20);
    repeat (19) cyc(1'b1, 1'b0);
    check("ar_pre_te", 32'(timerEnd_a), 0);
    cyc(1'b1, 1'b0);
    check("ar_te", 32'(timerEnd_a), 1);
    check("ar_count", 32'(count_a), 20);
    check("ar_running", 32'(running_a), 1);
    resetN_a = 1'b0;
    #1;
    check("ar_rst_count", 32'(count_a), 0);
    check("ar_rst_te", 32'(timerEnd_a), 0);
    check("ar_rst_running", 32'(running_a), 0);
    check("ar_rst_low", 32'(lowFuel_a), 0);
    cyc(1'b1, 1'b0);
    check("ar_rst_held", 32'(count_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fuel_countdown_ctrl.md
# fuel_countdown_ctrl

Parametrised countdown controller for the game's fuel/timer gauge, merging the arm/run/pause/hold control FSM and the down-counter into one block. Supports configurable width, load value, decrement step, saturating refill, low-level warning, multi-tick resume delay and optional auto-reload. Sits between the game-control logic (start, pause, refill events, one-second tick) and the HUD/game-over logic, which consume `count`, `lowFuel` and `timerEnd`.

## Interface
- `WIDTH`, 8: counter width in bits.
- `LOAD_VALUE`, 100: value loaded on arm and on auto-reload; also the refill ceiling; must be < 2**WIDTH.
- `DEC_STEP`, 1: amount subtracted per tick in RUN; must be ≥ 1.
- `REFILL`, 20: amount added per `refillPulse`.
- `LOW_THRESH`, 15: warning threshold.
- `HOLD_TICKS`, 1: ticks of resume delay after `waitN` releases; 0 means immediate resume.
- `AUTO_RELOAD`, 0: 1 means reload and keep running on expiry; 0 means return to idle.
- `clk` in 1: single clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startN` in 1: active-low start (level).
- `waitN` in 1: active-low pause request (level).
- `OneSecPulse` in 1: one-cycle tick strobe.
- `refillPulse` in 1: one-cycle refill strobe.
- `count` out WIDTH: current counter value.
- `timerEnd` out 1: one-cycle expiry pulse.
- `running` out 1: high in RUN.
- `lowFuel` out 1: high when `count` is in 1..LOW_THRESH.

## Operation
- States: S_IDLE, S_ARM, S_RUN, S_PAUSE, S_HOLD.
- S_IDLE: `count` holds its value. `startN`=0 moves to S_ARM.
- S_ARM: `count` is loaded with LOAD_VALUE every cycle. `startN`=1 moves to S_RUN.
- S_RUN, per cycle:
  - next = count − (tick ? DEC_STEP : 0) + (refill ? REFILL : 0).
  - Compute in WIDTH+2 bits; clamp to the range 0..LOAD_VALUE.
  - If `tick` is high and next = 0, the counter expires:
    - `timerEnd` pulses.
    - AUTO_RELOAD=1: `count` loads LOAD_VALUE and the state stays S_RUN.
    - AUTO_RELOAD=0: `count` becomes 0 and the state moves to S_IDLE.
  - Otherwise, `waitN`=0 moves to S_PAUSE; `count` still takes this cycle's update.
  - Expiry has priority over a pause request.
- S_PAUSE:
  - No decrement.
  - `refillPulse` still adds, saturating at LOAD_VALUE.
  - On `waitN`=1:
    - HOLD_TICKS=0: move to S_RUN.
    - HOLD_TICKS>0: move to S_HOLD and set the hold counter to HOLD_TICKS.
- S_HOLD:
  - No decrement; refill is allowed.
  - Each tick decrements the hold counter.
  - A tick while the hold counter = 1 moves to S_RUN.
  - `waitN`=0 returns to S_PAUSE; this has priority over the tick.
- `startN` is ignored outside S_IDLE. Restart is only possible via expiry (AUTO_RELOAD=0) or reset.
- Refill in S_IDLE/S_ARM is ignored.
- A refill arriving in the same cycle as a tick nets against the decrement. Expiry occurs only when the net result is 0.

## Timing
- Asynchronous reset values: state S_IDLE, `count`=0, hold counter=0, `timerEnd`=0, `running`=0, `lowFuel`=0.
- All state and `count` updates are registered; there is 1-cycle latency from an input to `count`/state.
- `timerEnd` is registered. It is high for exactly one cycle, the cycle after the expiring tick edge, coincident with `count`=0 (or `count`=LOAD_VALUE under auto-reload).
- `running` is decoded from the registered state. `lowFuel` is decoded from the registered `count` (glitch-free, no extra latency).
- Starting from an `OneSecPulse` or `refillPulse` high for one cycle, `count` changes at the next edge. A `count` of LOAD_VALUE needs ceil(LOAD_VALUE/DEC_STEP) ticks to expire.
- Reset mid-run clears everything immediately; no `timerEnd` is generated.

## Structure
- Package `fuel_pkg`: `fuel_state_t` enum (3-bit, the five states above) and shared default constants.
- One sub-module `fuel_sat_update`: combinational saturating add/subtract of `count`, step, refill and ceiling. It returns `next` and the `zero` flag.
- Top level holds the FSM, the `count` register, the hold counter (width $clog2(HOLD_TICKS+1), min 1) and the output registers.

## Test plan
Use WIDTH=8, LOAD_VALUE=20, DEC_STEP=1, REFILL=5, LOW_THRESH=5, HOLD_TICKS=2.
- Reset, then pulse `startN` low for 3 cycles and release -> `count`=20, `running`=1. After 20 ticks -> `timerEnd` is a single-cycle pulse, `count`=0, S_IDLE, `lowFuel`=0.
- At `count`=12, hold `waitN` low for 5 ticks -> `count` stays 12. Release `waitN` -> 2 ticks with no decrement, then decrement resumes (11 on the 3rd post-release tick).
- In S_HOLD after 1 tick, drop `waitN` -> S_PAUSE. Release -> the full 2-tick hold restarts.
- At `count`=18, refill -> 20 (saturated). At `count`=3, tick and refill in the same cycle -> 7, and `lowFuel` falls.
- AUTO_RELOAD=1, run to expiry -> `timerEnd` pulse, `count`=20, `running` stays 1. Assert `resetN` mid-run -> all outputs 0 asynchronously.
- At `count`=1, tick with `waitN`=0 in the same cycle -> expiry wins: `timerEnd`=1, S_IDLE.
